// File: rtl/if2_stage_pkg.sv
// Shared widths, stall-bit indices and types for the IF2 fetch stage.
// Imported by the stage top and its instruction hold buffer.
package if2_stage_pkg;

  localparam int STALL_WD   = 6;
  localparam int IF12IF2_WD = 33;
  localparam int IF22ID_WD  = 65;
  localparam int BR_WD      = 33;

  localparam int STALL_IF1 = 0;
  localparam int STALL_IF2 = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;

  // Bubble / NOP encoding seen by ID when no valid fetch is present.
  localparam logic [31:0] INST_NOP = 32'h0;

  typedef struct packed {
    logic        pc_valid;
    logic [31:0] pc;
  } if12if2_t;

  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_e;

endpackage

// File: rtl/if2_stage_inst_hold_buf.sv
// Keeps the SRAM read word alive across IF2 stalls so the fetched
// instruction reaches ID exactly once; also masks the inst for bubbles.
module if2_stage_inst_hold_buf
  import if2_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_stall,
  input  logic        i_pc_valid,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_inst
);

  hold_state_e r_state;
  logic [31:0] r_hold_inst;

  // SRAM data is only valid in the first stall cycle, so capture right then.
  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) begin
      r_state     <= HOLD_EMPTY;
      r_hold_inst <= INST_NOP;
    end else begin
      case (r_state)
        HOLD_EMPTY: begin
          if (i_stall && i_pc_valid) begin
            r_state     <= HOLD_FULL;
            r_hold_inst <= i_rdata;
          end
        end
        HOLD_FULL: begin
          if (!i_stall) begin
            r_state <= HOLD_EMPTY;
          end
        end
        default: r_state <= HOLD_EMPTY;
      endcase
    end
  end

  always_comb begin
    o_inst = INST_NOP;
    if (i_pc_valid) begin
      o_inst = (r_state == HOLD_FULL) ? r_hold_inst : i_rdata;
    end
  end

endmodule

// File: rtl/if2_stage.sv
// Second fetch stage: registers the IF1 bus, pairs it with the SRAM read
// word (or the held copy during stalls) and presents {inst, pc_valid, pc} to ID.
module if2_stage
  import if2_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [STALL_WD-1:0]   stall,
  input  logic [BR_WD-1:0]      br_bus,
  input  logic [IF12IF2_WD-1:0] if12if2_bus,
  input  logic [31:0]           inst_sram_rdata,
  output logic [IF22ID_WD-1:0]  if22id_bus
);

  if12if2_t    r_stage;
  if12if2_t    w_if1;
  logic        w_br_e;
  logic        w_stall_if2;
  logic        w_stall_id;
  logic        w_kill;
  logic [31:0] w_inst;
  logic        w_unused_bits;

  assign w_if1       = if12if2_t'(if12if2_bus);
  assign w_br_e      = br_bus[BR_WD-1];
  assign w_stall_if2 = stall[STALL_IF2];
  assign w_stall_id  = stall[STALL_ID];

  // A branch seen while stalled is deferred until the first non-stalled edge.
  assign w_kill = flush || (!w_stall_if2 && w_br_e);

  assign w_unused_bits = ^{br_bus[BR_WD-2:0], stall[STALL_WD-1:STALL_EX], stall[STALL_IF1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stage <= '0;
    end else if (flush) begin
      r_stage <= '0;
    end else if (w_stall_if2 && !w_stall_id) begin
      // ID drained this slot while IF2 is held: insert a bubble.
      r_stage <= '0;
    end else if (!w_stall_if2 && w_br_e) begin
      r_stage <= '0;
    end else if (!w_stall_if2) begin
      r_stage <= w_if1;
    end
  end

  if2_stage_inst_hold_buf u_hold (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (w_kill),
    .i_stall    (w_stall_if2),
    .i_pc_valid (r_stage.pc_valid),
    .i_rdata    (inst_sram_rdata),
    .o_inst     (w_inst)
  );

  assign if22id_bus = {w_inst, r_stage.pc_valid, r_stage.pc};

endmodule

// File: tb/tb_if2_stage.sv
// Directed bench for if2_stage: reset, stall capture, branch kill,
// flush, bubble insertion, back-to-back stalls and reset mid-stall.
module tb_if2_stage;
  import if2_stage_pkg::*;

  logic                  clk;
  logic                  rst_n;
  logic                  flush;
  logic [STALL_WD-1:0]   stall;
  logic [BR_WD-1:0]      br_bus;
  logic [IF12IF2_WD-1:0] if12if2_bus;
  logic [31:0]           inst_sram_rdata;
  logic [IF22ID_WD-1:0]  if22id_bus;

  int n_checks = 0;
  int n_pass   = 0;
  logic [IF22ID_WD-1:0] exp;

  localparam logic [STALL_WD-1:0] ST_NONE   = 6'b000000;
  localparam logic [STALL_WD-1:0] ST_IF2_ID = 6'b000110;
  localparam logic [STALL_WD-1:0] ST_IF2    = 6'b000010;

  if2_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush           (flush),
    .stall           (stall),
    .br_bus          (br_bus),
    .if12if2_bus     (if12if2_bus),
    .inst_sram_rdata (inst_sram_rdata),
    .if22id_bus      (if22id_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      rst_n           = 1'b0;
      flush           = 1'($urandom);
      stall           = 6'($urandom);
      br_bus          = {1'($urandom), 32'($urandom)};
      if12if2_bus     = {1'b1, 32'($urandom)};
      inst_sram_rdata = 32'($urandom);
      tick();
      n_checks++;
      if (if22id_bus !== 65'h0) $display("FAIL reset_cyc%0d got=%h exp=%h", i, if22id_bus, 65'h0);
      else n_pass++;
    end
    rst_n       = 1'b1;
    flush       = 1'b0;
    stall       = ST_NONE;
    br_bus      = '0;
    if12if2_bus = {1'b1, 32'h8000_0000};
    tick();
    inst_sram_rdata = 32'h0000_0013;
    #1;
    exp = {32'h0000_0013, 1'b1, 32'h8000_0000};
    n_checks++;
    if (if22id_bus !== exp) $display("FAIL reset_release got=%h exp=%h", if22id_bus, exp);
    else n_pass++;
  endtask

  task automatic test_stall_capture();
    if12if2_bus = {1'b1, 32'h8000_0004};
    tick();
    inst_sram_rdata = 32'h00A0_0093;
    #1;
    exp = {32'h00A0_0093, 1'b1, 32'h8000_0004};
    n_checks++;
    if (if22id_bus !== exp) $display("FAIL stall_pre got=%h exp=%h", if22id_bus, exp);
    else n_pass++;
    stall       = ST_IF2_ID;
    if12if2_bus = {1'b1, 32'h8000_0008};
    for (int i = 0; i < 4; i++) begin
      tick();
      inst_sram_rdata = 32'hDEAD_BEEF;
      #1;
      n_checks++;
      if (if22id_bus !== exp) $display("FAIL stall_hold%0d got=%h exp=%h", i, if22id_bus, exp);
      else n_pass++;
    end
    stall = ST_NONE;
    tick();
    inst_sram_rdata = 32'h0010_0113;
    #1;
    exp = {32'h0010_0113, 1'b1, 32'h8000_0008};
    n_checks++;
    if (if22id_bus !== exp) $display("FAIL stall_release got=%h exp=%h", if22id_bus, exp);
    else n_pass++;
  endtask

  task automatic test_branch_kill();
    if12if2_bus = {1'b1, 32'h8000_0010};
    tick();
    inst_sram_rdata = 32'h0000_0063;
    #1;
    exp = {32'h0000_0063, 1'b1, 32'h8000_0010};
    n_checks++;
    if (if22id_bus !== exp) $display("FAIL br_pre got=%h exp=%h", if22id_bus, exp);
    else n_pass++;
    br_bus      = {1'b1, 32'h8000_0040};
    if12if2_bus = {1'b1, 32'h8000_0014};
    tick();
    inst_sram_rdata = 32'h1234_5678;
    #1;
    n_checks++;
    if (if22id_bus !== 65'h0) $display("FAIL br_kill got=%h exp=%h", if22id_bus, 65'h0);
    else n_pass++;
    br_bus      = '0;
    if12if2_bus = {1'b1, 32'h8000_0040};
    tick();
    inst_sram_rdata = 32'h0000_0517;
    #1;
    exp = {32'h0000_0517, 1'b1, 32'h8000_0040};
    n_checks++;
    if (if22id_bus !== exp) $display("FAIL br_target got=%h exp=%h", if22id_bus, exp);
    else n_pass++;
  endtask

  task automatic test_branch_during_stall();
    stall  = ST_IF2_ID;
    br_bus = {1'b1, 32'h8000_0100};
    for (int i = 0; i < 2; i++) begin
      tick();
      inst_sram_rdata = 32'hBAD0_0000 + 32'(i);
      #1;
      n_checks++;
      if (if22id_bus !== exp) $display("FAIL brstall_hold%0d got=%h exp=%h", i, if22id_bus, exp);
      else n_pass++;
    end
    stall       = ST_NONE;
    if12if2_bus = {1'b1, 32'h8000_0044};
    tick();
    n_checks++;
    if (if22id_bus !== 65'h0) $display("FAIL brstall_kill got=%h exp=%h", if22id_bus, 65'h0);
    else n_pass++;
    br_bus      = '0;
    if12if2_bus = {1'b1, 32'h8000_0100};
    tick();
    inst_sram_rdata = 32'h0000_0011;
    #1;
    exp = {32'h0000_0011, 1'b1, 32'h8000_0100};
    n_checks++;
    if (if22id_bus !== exp) $display("FAIL brstall_target got=%h exp=%h", if22id_bus, exp);
    else n_pass++;
  endtask

  task automatic test_flush_with_stall();
    stall       = ST_IF2_ID;
    if12if2_bus = {1'b1, 32'h8000_0104};
    tick();
    inst_sram_rdata = 32'hCAFE_F00D;
    #1;
    n_checks++;
    if (if22id_bus !== exp) $display("FAIL flush_hold got=%h exp=%h", if22id_bus, exp);
    else n_pass++;
    flush = 1'b1;
    tick();
    n_checks++;
    if (if22id_bus !== 65'h0) $display("FAIL flush_clear got=%h exp=%h", if22id_bus, 65'h0);
    else n_pass++;
    flush       = 1'b0;
    stall       = ST_NONE;
    if12if2_bus = {1'b1, 32'h8000_0200};
    tick();
    inst_sram_rdata = 32'h0000_0022;
    #1;
    exp = {32'h0000_0022, 1'b1, 32'h8000_0200};
    n_checks++;
    if (if22id_bus !== exp) $display("FAIL flush_resume got=%h exp=%h", if22id_bus, exp);
    else n_pass++;
  endtask

  task automatic test_bubble_insert();
    stall       = ST_IF2;
    if12if2_bus = {1'b1, 32'h8000_0204};
    tick();
    inst_sram_rdata = 32'hFFFF_FFFF;
    #1;
    n_checks++;
    if (if22id_bus !== 65'h0) $display("FAIL bubble got=%h exp=%h", if22id_bus, 65'h0);
    else n_pass++;
    stall = ST_NONE;
    tick();
    inst_sram_rdata = 32'h0000_0033;
    #1;
    exp = {32'h0000_0033, 1'b1, 32'h8000_0204};
    n_checks++;
    if (if22id_bus !== exp) $display("FAIL bubble_next got=%h exp=%h", if22id_bus, exp);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs [2]   = '{32'h8000_0208, 32'h8000_020C};
    logic [31:0] insts [2] = '{32'h0000_0044, 32'h0000_0055};
    for (int i = 0; i < 2; i++) begin
      stall = ST_IF2_ID;
      if12if2_bus = {1'b1, pcs[i]};
      tick();
      inst_sram_rdata = 32'h5A5A_0000 + 32'(i);
      #1;
      n_checks++;
      if (if22id_bus !== exp) $display("FAIL b2b_hold%0d got=%h exp=%h", i, if22id_bus, exp);
      else n_pass++;
      stall = ST_NONE;
      tick();
      inst_sram_rdata = insts[i];
      #1;
      exp = {insts[i], 1'b1, pcs[i]};
      n_checks++;
      if (if22id_bus !== exp) $display("FAIL b2b_next%0d got=%h exp=%h", i, if22id_bus, exp);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_stall();
    stall       = ST_IF2_ID;
    if12if2_bus = {1'b1, 32'h8000_0210};
    tick();
    inst_sram_rdata = 32'h7777_7777;
    #1;
    n_checks++;
    if (if22id_bus !== exp) $display("FAIL rststall_hold got=%h exp=%h", if22id_bus, exp);
    else n_pass++;
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (if22id_bus !== 65'h0) $display("FAIL rststall_clear got=%h exp=%h", if22id_bus, 65'h0);
    else n_pass++;
    rst_n = 1'b1;
    tick();
    inst_sram_rdata = 32'h8888_8888;
    #1;
    n_checks++;
    if (if22id_bus !== 65'h0) $display("FAIL rststall_after got=%h exp=%h", if22id_bus, 65'h0);
    else n_pass++;
  endtask

  initial begin
    rst_n           = 1'b0;
    flush           = 1'b0;
    stall           = ST_NONE;
    br_bus          = '0;
    if12if2_bus     = '0;
    inst_sram_rdata = '0;
    exp             = '0;
    test_reset();
    test_stall_capture();
    test_branch_kill();
    test_branch_during_stall();
    test_flush_with_stall();
    test_bubble_insert();
    test_back_to_back();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
